// File: rtl/dmem_responder.sv
// Multi-channel valid/ready memory responder: one shared data RAM, one independent
// request FSM with a latency down-counter per channel.
module dmem_responder #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int MEM_DEPTH     = 2 ** ADDR_BITS,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              init_valid,
    input  logic [ADDR_BITS-1:0]              init_address,
    input  logic [DATA_BITS-1:0]              init_data
);
    // state     | meaning
    // IDLE      | waiting for a request; write beats read
    // BUSY      | counting down latency; abort if the serviced valid drops
    // RESP      | ready pulse is high this cycle
    // RELEASE   | waiting for the serviced valid to fall before re-arming
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_BITS = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int IDX_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_BITS-1:0] ram [MEM_DEPTH];

    logic [1:0]           state    [NUM_CHANNELS];
    logic [CNT_BITS-1:0]  cnt      [NUM_CHANNELS];
    logic                 op_write [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr     [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata    [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] svc_valid;
    logic [NUM_CHANNELS-1:0] in_range;
    logic [NUM_CHANNELS-1:0] ram_we;

    always_comb begin
        svc_valid = '0;
        in_range  = '0;
        ram_we    = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            svc_valid[ch] = op_write[ch] ? mem_write_valid[ch] : mem_read_valid[ch];
            in_range[ch]  = int'(addr[ch]) < MEM_DEPTH;
            ram_we[ch]    = !reset && (state[ch] == ST_BUSY) && svc_valid[ch] &&
                            (cnt[ch] == '0) && op_write[ch] && in_range[ch];
        end
    end

    // Later assignments win, so init loses to any channel and higher channels win ties.
    always_ff @(posedge clk) begin
        if (init_valid && (int'(init_address) < MEM_DEPTH))
            ram[init_address[IDX_BITS-1:0]] <= init_data;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ram_we[ch])
                ram[addr[ch][IDX_BITS-1:0]] <= wdata[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]    <= ST_IDLE;
                cnt[ch]      <= '0;
                op_write[ch] <= 1'b0;
                addr[ch]     <= '0;
                wdata[ch]    <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    ST_IDLE: begin
                        if (mem_write_valid[ch]) begin
                            op_write[ch] <= 1'b1;
                            addr[ch]     <= mem_write_address[ch*ADDR_BITS +: ADDR_BITS];
                            wdata[ch]    <= mem_write_data[ch*DATA_BITS +: DATA_BITS];
                            cnt[ch]      <= CNT_BITS'(WRITE_LATENCY - 1);
                            state[ch]    <= ST_BUSY;
                        end else if (mem_read_valid[ch]) begin
                            op_write[ch] <= 1'b0;
                            addr[ch]     <= mem_read_address[ch*ADDR_BITS +: ADDR_BITS];
                            cnt[ch]      <= CNT_BITS'(READ_LATENCY - 1);
                            state[ch]    <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (!svc_valid[ch]) begin
                            state[ch] <= ST_IDLE;
                        end else if (cnt[ch] == '0) begin
                            if (op_write[ch]) begin
                                mem_write_ready[ch] <= 1'b1;
                            end else begin
                                mem_read_ready[ch] <= 1'b1;
                                mem_read_data[ch*DATA_BITS +: DATA_BITS] <=
                                    in_range[ch] ? ram[addr[ch][IDX_BITS-1:0]] : '0;
                            end
                            state[ch] <= ST_RESP;
                        end else begin
                            cnt[ch] <= cnt[ch] - 1'b1;
                        end
                    end
                    ST_RESP: begin
                        mem_read_ready[ch]  <= 1'b0;
                        mem_write_ready[ch] <= 1'b0;
                        state[ch]           <= ST_RELEASE;
                    end
                    default: begin
                        if (!svc_valid[ch])
                            state[ch] <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
